// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute sequencer for the 4-bit processor.
// Owns the phase FSM, the instruction latch, the C/Z flag register, the
// OUT-port valid/ready handshake and a retired-instruction counter.
// Decode strobes are passed through only in legal, non-stalled cycles.
module exec_sequencer #(
  parameter int INSTR_W = 4,
  parameter int OPRND_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       step_i,
  input  logic [INSTR_W+OPRND_W-1:0] prog_byte_i,
  input  logic                       alu_c_i,
  input  logic                       alu_z_i,
  input  logic                       dec_inc_pc_i,
  input  logic                       dec_load_pc_i,
  input  logic                       dec_load_a_i,
  input  logic                       dec_load_flags_i,
  input  logic                       dec_load_out_i,
  input  logic                       out_ready_i,
  output logic                       phase_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [OPRND_W-1:0]         oprnd_o,
  output logic                       c_flag_o,
  output logic                       z_flag_o,
  output logic                       inc_pc_o,
  output logic                       load_pc_o,
  output logic                       load_a_o,
  output logic                       load_flags_o,
  output logic                       load_out_o,
  output logic                       out_valid_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           retired_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [OPRND_W-1:0] oprnd_q;
  logic               c_q, z_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   retired_q;
  logic               stall;
  logic               complete;

  // A new OUT cannot overwrite a value the consumer has not yet taken.
  assign stall = dec_load_out_i & out_valid_q & ~out_ready_i;

  // Next-state and strobe qualification; reset kills strobes in the same cycle.
  always_comb begin
    state_d      = state_q;
    phase_o      = 1'b0;
    inc_pc_o     = 1'b0;
    load_pc_o    = 1'b0;
    load_a_o     = 1'b0;
    load_flags_o = 1'b0;
    load_out_o   = 1'b0;
    complete     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i || step_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        inc_pc_o = dec_inc_pc_i;
        state_d  = S_EXEC;
      end
      S_EXEC, S_WAIT: begin
        phase_o = 1'b1;
        if (stall) begin
          state_d = S_WAIT;
        end else begin
          inc_pc_o     = dec_inc_pc_i;
          load_pc_o    = dec_load_pc_i;
          load_a_o     = dec_load_a_i;
          load_flags_o = dec_load_flags_i;
          load_out_o   = dec_load_out_i;
          complete     = 1'b1;
          state_d      = enable_i ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset_i) begin
      inc_pc_o     = 1'b0;
      load_pc_o    = 1'b0;
      load_a_o     = 1'b0;
      load_flags_o = 1'b0;
      load_out_o   = 1'b0;
      complete     = 1'b0;
    end
  end

  // State, instruction latch, flags, OUT handshake and retire counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      oprnd_q     <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        instr_q <= prog_byte_i[INSTR_W+OPRND_W-1:OPRND_W];
        oprnd_q <= prog_byte_i[OPRND_W-1:0];
      end
      if (load_flags_o) begin
        c_q <= alu_c_i;
        z_q <= alu_z_i;
      end
      // A new load wins over a same-cycle acknowledge.
      if (load_out_o)       out_valid_q <= 1'b1;
      else if (out_ready_i) out_valid_q <= 1'b0;
      if (complete) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign instr_o     = instr_q;
  assign oprnd_o     = oprnd_q;
  assign c_flag_o    = c_q;
  assign z_flag_o    = z_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign retired_o   = retired_q;

endmodule
